// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader_if
//  Description : Handshake and write-bus bundle between a byte-stream source /
//                instruction memory (master side) and the instruction-memory
//                loader (slave side).
//                  Start    - single-cycle load request (master -> loader)
//                  RxData   - incoming byte                (master -> loader)
//                  RxValid  - RxData valid                 (master -> loader)
//                  RxReady  - loader accepts a byte        (loader -> master)
//                  WE       - instruction-memory write     (loader -> master)
//                  WAddr    - word-aligned byte address    (loader -> master)
//                  WData    - instruction word             (loader -> master)
//                  Busy     - load in progress, holds PC   (loader -> master)
//                  Done     - sticky load-complete flag    (loader -> master)
//                  Error    - sticky bad-length flag       (loader -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if;
   logic        Start;
   logic [7:0]  RxData;
   logic        RxValid;
   logic        RxReady;
   logic        WE;
   logic [31:0] WAddr;
   logic [31:0] WData;
   logic        Busy;
   logic        Done;
   logic        Error;

   modport master (
      output Start, RxData, RxValid,
      input  RxReady, WE, WAddr, WData, Busy, Done, Error
   );

   modport slave (
      input  Start, RxData, RxValid,
      output RxReady, WE, WAddr, WData, Busy, Done, Error
   );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Loads a program into instruction memory from a byte stream.
//                Stream format: 16-bit little-endian word count, then that
//                many 32-bit little-endian instruction words. Each complete
//                word is written with a one-cycle WE strobe at WAddr =
//                index*4. A count of 0 or above DEPTH sets a sticky Error.
//  Ports       : CLK    - clock, rising edge
//                RESETn - asynchronous active-low reset
//                bus    - instr_mem_loader_if.slave (Start, Rx handshake,
//                         write bus, Busy/Done/Error status)
//  Parameters  : DEPTH  - instruction-memory depth in 32-bit words
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
   parameter int DEPTH = 128
) (
   input wire logic          CLK,
   input wire logic          RESETn,
   instr_mem_loader_if.slave bus
);

   localparam int          c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0] c_DEPTH = 17'(DEPTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN0  = 3'd1,
      LEN1  = 3'd2,
      DATA  = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } state_t;

   state_t               r_state;
   logic                 r_rx_ready;
   logic                 r_we;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_error;
   logic [31:0]          r_waddr;
   logic [31:0]          r_wdata;
   logic [15:0]          r_count;
   logic [c_IDX_W-1:0]   r_word_idx;
   logic [1:0]           r_byte_idx;
   // Bytes 0..2 of the word being assembled; kept apart from r_wdata so the
   // write bus holds the previous word until the next write.
   logic [23:0]          r_asm;

   logic                 w_xfer;
   logic [15:0]          w_len;
   logic                 w_len_bad;
   logic [16:0]          w_idx_inc;
   logic                 w_last;
   logic [31:0]          w_waddr;

   assign w_xfer    = bus.RxValid & r_rx_ready;
   // Full count as it will be once the high byte in LEN1 is latched.
   assign w_len     = {bus.RxData, r_count[7:0]};
   assign w_len_bad = (w_len == 16'd0) || ({1'b0, w_len} > c_DEPTH);
   // Incremented index kept at 17 bits so a count equal to DEPTH compares
   // correctly even though the stored index never reaches DEPTH.
   assign w_idx_inc = 17'(r_word_idx) + 17'd1;
   assign w_last    = (w_idx_inc == {1'b0, r_count});
   assign w_waddr   = 32'(r_word_idx) << 2;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state    <= IDLE;
         r_rx_ready <= 1'b0;
         r_we       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_waddr    <= 32'd0;
         r_wdata    <= 32'd0;
         r_count    <= 16'd0;
         r_word_idx <= '0;
         r_byte_idx <= 2'd0;
         r_asm      <= 24'd0;
      end else begin
         case (r_state)
            IDLE, DONE, ERR: begin
               if (bus.Start) begin
                  r_state    <= LEN0;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
                  r_count    <= 16'd0;
                  r_word_idx <= '0;
                  r_byte_idx <= 2'd0;
                  r_rx_ready <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end

            LEN0: begin
               if (w_xfer) begin
                  r_count[7:0] <= bus.RxData;
                  r_state      <= LEN1;
               end
            end

            LEN1: begin
               if (w_xfer) begin
                  r_count[15:8] <= bus.RxData;
                  if (w_len_bad) begin
                     r_state    <= ERR;
                     r_error    <= 1'b1;
                     r_rx_ready <= 1'b0;
                     r_busy     <= 1'b0;
                  end else begin
                     r_state    <= DATA;
                  end
               end
            end

            DATA: begin
               if (w_xfer) begin
                  r_byte_idx <= r_byte_idx + 2'd1;
                  case (r_byte_idx)
                     2'd0: r_asm[7:0]   <= bus.RxData;
                     2'd1: r_asm[15:8]  <= bus.RxData;
                     2'd2: r_asm[23:16] <= bus.RxData;
                     default: begin
                        r_wdata    <= {bus.RxData, r_asm};
                        r_waddr    <= w_waddr;
                        r_we       <= 1'b1;
                        r_rx_ready <= 1'b0;
                        r_state    <= WRITE;
                     end
                  endcase
               end
            end

            WRITE: begin
               r_we <= 1'b0;
               if (w_last) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_word_idx <= w_idx_inc[c_IDX_W-1:0];
                  r_rx_ready <= 1'b1;
                  r_state    <= DATA;
               end
            end

            default: begin
               r_state    <= IDLE;
               r_rx_ready <= 1'b0;
               r_we       <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.RxReady = r_rx_ready;
   assign bus.WE      = r_we;
   assign bus.WAddr   = r_waddr;
   assign bus.WData   = r_wdata;
   assign bus.Busy    = r_busy;
   assign bus.Done    = r_done;
   assign bus.Error   = r_error;

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128, instruction-memory depth in 32-bit words.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port RESETn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port Start  input  1  single-cycle request to begin a load.
REQ-005 SHALL have port RxData  input  8  incoming byte stream.
REQ-006 SHALL have port RxValid  input  1  RxData valid.
REQ-007 SHALL have port RxReady  output  1  loader accepts a byte; a transfer occurs when RxValid and RxReady are both 1.
REQ-008 SHALL have port WE  output  1  instruction-memory write strobe.
REQ-009 SHALL have port WAddr  output  32  byte address of the write, word-aligned; the memory indexes words by WAddr[31:2].
REQ-010 SHALL have port WData  output  32  instruction word to write.
REQ-011 SHALL have port Busy  output  1  load in progress; also holds the processor PC in reset.
REQ-012 SHALL have port Done  output  1  sticky load-complete flag.
REQ-013 SHALL have port Error  output  1  sticky bad-length flag.

Function
REQ-014 SHALL implement the states IDLE, LEN0, LEN1, DATA, WRITE, DONE and ERR.
REQ-015 SHALL leave IDLE, DONE or ERR for LEN0 on Start=1, clearing Done, Error, the word index and the byte index.
REQ-016 SHALL ignore Start in LEN0, LEN1, DATA and WRITE.
REQ-017 SHALL drive RxReady=1 only in LEN0, LEN1 and DATA.
REQ-018 SHALL latch the accepted byte as Count[7:0] in LEN0, then go to LEN1.
REQ-019 SHALL latch the accepted byte as Count[15:8] in LEN1.
REQ-020 SHALL, after LEN1, go to ERR when Count is 0 or greater than DEPTH, and to DATA otherwise.
REQ-021 SHALL assemble words little-endian in DATA: byte index k (0..3) is placed in WData[8k+7:8k], and k wraps 3->0.
REQ-022 SHALL go from DATA to WRITE on the 4th accepted byte, so WE=1 in the cycle after that byte's handshake (latency 1).
REQ-023 SHALL hold WE=1 for exactly one cycle in WRITE, with WAddr = word_index*4 and WData stable.
REQ-024 SHALL increment word_index in WRITE, then go to DONE when the incremented value equals Count, and to DATA otherwise.
REQ-025 SHALL hold WE=0 in every state other than WRITE.
REQ-026 SHALL hold WAddr and WData at their last values between writes.
REQ-027 SHALL keep Busy=1 in LEN0, LEN1, DATA and WRITE, and Busy=0 otherwise.
REQ-028 SHALL hold Done=1 in DONE and Error=1 in ERR until the next accepted Start.
REQ-029 SHALL never issue a write in ERR.
REQ-030 SHALL keep RxReady=0 in WRITE, so a byte offered during WRITE stalls and is not lost.
REQ-031 SHALL tolerate RxValid gaps of any length in LEN0, LEN1 and DATA, with no timeout.
REQ-032 SHALL limit the word index to the range 0..DEPTH-1; the 16-bit Count is compared at full width.

Reset
REQ-033 SHALL, while RESETn=0, force state IDLE, and drive RxReady, WE, Busy, Done and Error to 0, WAddr and WData to 0, and Count and all indices to 0.
REQ-034 SHALL, on reset during a load, discard any partial word; words already written are not rolled back.
REQ-035 SHALL, after RESETn deasserts, wait for Start in IDLE.

Verification
REQ-036 SHALL cover: Start; bytes 02 00, 37 B0 FF FF, 13 00 00 00 -> WE at WAddr 0x0 with WData 0xFFFFB037, then WAddr 0x4 with 0x00000013; Done=1; Busy=0.
REQ-037 SHALL cover: Start with Count=0, then Count=129 -> Error=1, WE never asserted, RxReady=0 after the 2nd byte.
REQ-038 SHALL cover: Count=128, all bytes back-to-back -> 128 writes, last at WAddr 0x1FC, Done=1.
REQ-039 SHALL cover: RxValid toggled randomly during DATA -> the same write sequence as with a gap-free stream.
REQ-040 SHALL cover: RESETn pulsed low after 6 data bytes -> all outputs 0 immediately; a following Start reloads from WAddr 0x0.
REQ-041 SHALL cover: Start pulsed in DATA -> ignored; Start in DONE -> Done clears next cycle, state LEN0.
